// File: rtl/lab2_proc_pkg.sv
// Shared lab2_proc definitions.
// Holds a few TinyRV2 encoding constants used around the fetch path, plus the
// width helpers for the instruction-response buffer counters and pointers.
// No ports (package).
package lab2_proc_pkg;

    localparam int unsigned c_word_w = 32;

    // TinyRV2 encoding constants
    localparam logic [31:0] c_tinyrv2_nop     = 32'h0000_0013;
    localparam logic [6:0]  c_tinyrv2_op_jal  = 7'b110_1111;
    localparam logic [6:0]  c_tinyrv2_op_br   = 7'b110_0011;

    // Counter width: outstanding requests can reach twice the credit limit
    // (one full window being dropped plus one full live window).
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(2 * n + 1);
    endfunction

    // Pointer width for an n-entry FIFO; at least one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lab2_proc_imem_resp_buffer_chk.sv
// Simulation checker for the instruction-response buffer: credit protocol
// and counter invariants.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_imem_req_fire  : request accepted this cycle
//   i_imem_req_rdy   : credit available
//   i_inflight       : outstanding request count
//   i_drop           : responses still to be discarded
//   i_credit_sum     : live requests plus buffered words
module lab2_proc_imem_resp_buffer_chk #(
    parameter int unsigned p_num_entries = 2,
    parameter int unsigned W             = 3
) (
    input logic         i_clk,
    input logic         i_reset,
    input logic         i_imem_req_fire,
    input logic         i_imem_req_rdy,
    input logic [W-1:0] i_inflight,
    input logic [W-1:0] i_drop,
    input logic [W:0]   i_credit_sum
);

    a_fire_needs_credit: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_imem_req_fire && !i_imem_req_rdy));

    a_drop_le_inflight: assert property (@(posedge i_clk) disable iff (i_reset)
        i_drop <= i_inflight);

    a_credit_bound: assert property (@(posedge i_clk) disable iff (i_reset)
        i_credit_sum <= (W+1)'(p_num_entries));

endmodule

// File: rtl/lab2_proc_imem_resp_fifo.sv
// Small FIFO holding live instruction words for the response buffer.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_enq, i_enq_data: write one word
//   i_deq            : pop the head word
//   i_flush          : drop all contents and reset pointers (wins over enq/deq)
//   o_head           : word at the read pointer
//   o_count          : current occupancy
module lab2_proc_imem_resp_fifo
    import lab2_proc_pkg::*;
#(
    parameter  int unsigned p_depth = 2,
    localparam int unsigned CW      = $clog2(p_depth + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_enq,
    input  logic [31:0]   i_enq_data,
    input  logic          i_deq,
    input  logic          i_flush,
    output logic [31:0]   o_head,
    output logic [CW-1:0] o_count
);

    localparam int unsigned      PW     = ptr_width(p_depth);
    localparam logic [PW-1:0]    c_last = PW'(p_depth - 1);

    logic [31:0]   r_mem [p_depth];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Explicit compare so non-power-of-2 depths wrap correctly.
    function automatic logic [PW-1:0] ptr_incr(input logic [PW-1:0] p);
        return (p == c_last) ? {PW{1'b0}} : p + PW'(1'b1);
    endfunction

    // Pointer and occupancy state
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (i_enq) begin
                r_wr_ptr <= ptr_incr(r_wr_ptr);
            end
            if (i_deq) begin
                r_rd_ptr <= ptr_incr(r_rd_ptr);
            end
            r_count <= r_count + CW'(i_enq) - CW'(i_deq);
        end
    end

    // Word storage
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(p_depth); i++) begin
                r_mem[i] <= {32{1'b0}};
            end
        end else if (i_enq && !i_flush) begin
            r_mem[r_wr_ptr] <= i_enq_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/lab2_proc_imem_resp_buffer.sv
// Credit-managed instruction-response buffer between imem responses and the
// F/D boundary. Tracks in-flight fetches, discards responses that belong to
// squashed fetches, and queues live words in a bypass FIFO so D only sees
// valid, in-order, non-squashed instructions.
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_imem_req_fire     : imem request accepted this cycle
//   o_imem_req_rdy      : a credit is available for a new request
//   i_squash            : redirect; older outstanding fetches become dead
//   i_imem_resp_val/data: imem response (o_imem_resp_rdy is 1 out of reset)
//   o_out_val/data      : instruction toward D, i_out_rdy is D's enable
//   o_num_inflight      : outstanding requests
//   o_num_drop          : responses still to be discarded
module lab2_proc_imem_resp_buffer
    import lab2_proc_pkg::*;
#(
    parameter  int unsigned p_num_entries = 2,
    localparam int unsigned W             = cnt_width(p_num_entries)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_imem_req_fire,
    output logic         o_imem_req_rdy,
    input  logic         i_squash,
    input  logic         i_imem_resp_val,
    output logic         o_imem_resp_rdy,
    input  logic [31:0]  i_imem_resp_data,
    output logic         o_out_val,
    input  logic         i_out_rdy,
    output logic [31:0]  o_out_data,
    output logic [W-1:0] o_num_inflight,
    output logic [W-1:0] o_num_drop
);

    localparam int unsigned CW = $clog2(p_num_entries + 1);

    logic [W-1:0]  r_inflight;
    logic [W-1:0]  r_drop;

    logic          w_resp_fire;
    logic [W-1:0]  w_live;
    logic [W:0]    w_credit_sum;
    logic          w_drop_resp;
    logic          w_live_resp;
    logic          w_fifo_nonempty;
    logic          w_enq;
    logic          w_deq;
    logic [31:0]   w_fifo_head;
    logic [CW-1:0] w_fifo_count;

    // Response classification, credits and FIFO control
    always_comb begin
        w_resp_fire     = i_imem_resp_val;
        w_live          = r_inflight - r_drop;
        w_credit_sum    = {1'b0, w_live} + (W+1)'(w_fifo_count);
        w_fifo_nonempty = (w_fifo_count != {CW{1'b0}});
        w_drop_resp     = w_resp_fire && (r_drop != {W{1'b0}});
        // On a squash every arriving response is dead, whatever drop_pending says.
        w_live_resp     = w_resp_fire && (r_drop == {W{1'b0}}) && !i_squash;
        // out_val deliberately ignores i_out_rdy.
        o_out_val       = !i_reset && !i_squash && (w_fifo_nonempty || w_live_resp);
        if (w_fifo_nonempty) begin
            o_out_data = w_fifo_head;
        end else begin
            o_out_data = i_imem_resp_data;
        end
        w_deq           = o_out_val && i_out_rdy && w_fifo_nonempty;
        // Bypass when the FIFO is empty and D is taking the word now.
        w_enq           = w_live_resp && !(!w_fifo_nonempty && i_out_rdy);
        o_imem_req_rdy  = !i_reset && (w_credit_sum < (W+1)'(p_num_entries));
        o_imem_resp_rdy = !i_reset;
    end

    // In-flight and drop-pending counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_inflight <= {W{1'b0}};
            r_drop     <= {W{1'b0}};
        end else begin
            r_inflight <= r_inflight + W'(i_imem_req_fire) - W'(w_resp_fire);
            if (i_squash) begin
                // Everything outstanding before this cycle is dead; a request
                // firing now belongs to the new stream and stays live.
                r_drop <= r_inflight - W'(w_resp_fire);
            end else begin
                r_drop <= r_drop - W'(w_drop_resp);
            end
        end
    end

    assign o_num_inflight = r_inflight;
    assign o_num_drop     = r_drop;

    lab2_proc_imem_resp_fifo #(
        .p_depth (p_num_entries)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enq      (w_enq),
        .i_enq_data (i_imem_resp_data),
        .i_deq      (w_deq),
        .i_flush    (i_squash),
        .o_head     (w_fifo_head),
        .o_count    (w_fifo_count)
    );

    lab2_proc_imem_resp_buffer_chk #(
        .p_num_entries (p_num_entries),
        .W             (W)
    ) u_chk (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_imem_req_fire (i_imem_req_fire),
        .i_imem_req_rdy  (o_imem_req_rdy),
        .i_inflight      (r_inflight),
        .i_drop          (r_drop),
        .i_credit_sum    (w_credit_sum)
    );

endmodule

// File: tb/tb_lab2_proc_imem_resp_buffer.sv
// Directed, table-driven bench for lab2_proc_imem_resp_buffer (depth 2).
// Each record is one clock cycle: inputs applied after the falling edge,
// outputs compared 1 time unit later, state advances on the rising edge.
module tb_lab2_proc_imem_resp_buffer;

    localparam int unsigned N = 2;
    localparam int unsigned W = $clog2(2 * N + 1);

    logic         clk;
    logic         reset;
    logic         req_fire;
    logic         req_rdy;
    logic         squash;
    logic         resp_val;
    logic         resp_rdy;
    logic [31:0]  resp_data;
    logic         out_val;
    logic         out_rdy;
    logic [31:0]  out_data;
    logic [W-1:0] num_inflight;
    logic [W-1:0] num_drop;

    typedef struct {
        string       name;
        logic        rst;
        logic        fire;
        logic        sq;
        logic        rv;
        logic [31:0] rdata;
        logic        ordy;
        logic        e_req_rdy;
        logic        e_resp_rdy;
        logic        e_oval;
        logic [31:0] e_odata;
        int          e_inf;
        int          e_drop;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    lab2_proc_imem_resp_buffer #(.p_num_entries(N)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_imem_req_fire  (req_fire),
        .o_imem_req_rdy   (req_rdy),
        .i_squash         (squash),
        .i_imem_resp_val  (resp_val),
        .o_imem_resp_rdy  (resp_rdy),
        .i_imem_resp_data (resp_data),
        .o_out_val        (out_val),
        .i_out_rdy        (out_rdy),
        .o_out_data       (out_data),
        .o_num_inflight   (num_inflight),
        .o_num_drop       (num_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic rst, input logic fire,
                                input logic sq, input logic rv, input logic [31:0] rd,
                                input logic ordy, input logic e_rq, input logic e_rs,
                                input logic e_ov, input logic [31:0] e_od,
                                input int e_inf, input int e_dr);
        vec_t v;
        v.name = nm; v.rst = rst; v.fire = fire; v.sq = sq; v.rv = rv;
        v.rdata = rd; v.ordy = ordy; v.e_req_rdy = e_rq; v.e_resp_rdy = e_rs;
        v.e_oval = e_ov; v.e_odata = e_od; v.e_inf = e_inf; v.e_drop = e_dr;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset     = v.rst;
        req_fire  = v.fire;
        squash    = v.sq;
        resp_val  = v.rv;
        resp_data = v.rdata;
        out_rdy   = v.ordy;
        #1;
        n_vec++;
        if (req_rdy !== v.e_req_rdy) begin
            n_err++;
            $display("FAIL %s req_rdy: got %b want %b", v.name, req_rdy, v.e_req_rdy);
        end
        if (resp_rdy !== v.e_resp_rdy) begin
            n_err++;
            $display("FAIL %s resp_rdy: got %b want %b", v.name, resp_rdy, v.e_resp_rdy);
        end
        if (out_val !== v.e_oval) begin
            n_err++;
            $display("FAIL %s out_val: got %b want %b", v.name, out_val, v.e_oval);
        end
        if (v.e_oval && (out_data !== v.e_odata)) begin
            n_err++;
            $display("FAIL %s out_data: got %h want %h", v.name, out_data, v.e_odata);
        end
        if (num_inflight !== W'(v.e_inf)) begin
            n_err++;
            $display("FAIL %s num_inflight: got %0d want %0d", v.name, num_inflight, v.e_inf);
        end
        if (num_drop !== W'(v.e_drop)) begin
            n_err++;
            $display("FAIL %s num_drop: got %0d want %0d", v.name, num_drop, v.e_drop);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; req_fire = 1'b0; squash = 1'b0;
        resp_val = 1'b0; resp_data = 32'h0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);

        //           name        rst   fire  sq    rv    rdata          ordy  e_rq  e_rs  e_ov  e_odata        inf dr
        // reset state
        tbl.push_back(mk("rst",   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         0, 0));
        // back-to-back fetch with bypass
        tbl.push_back(mk("b2b0",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        tbl.push_back(mk("b2b1",  1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 1, 0));
        tbl.push_back(mk("b2b2",  1'b0, 1'b0, 1'b0, 1'b1, 32'h0010_0093, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0010_0093, 1, 0));
        tbl.push_back(mk("b2b3",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        // stall then drain
        tbl.push_back(mk("stl0",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        tbl.push_back(mk("stl1",  1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 1, 0));
        tbl.push_back(mk("stl2",  1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1, 0));
        tbl.push_back(mk("stl3",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 0, 0));
        tbl.push_back(mk("drn0",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 0, 0));
        tbl.push_back(mk("drn1",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h2222_2222, 0, 0));
        tbl.push_back(mk("drn2",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        // squash with two in flight, then drop two, third is live
        tbl.push_back(mk("sq2a",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        tbl.push_back(mk("sq2b",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1, 0));
        tbl.push_back(mk("sq2c",  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         2, 0));
        tbl.push_back(mk("sq2d",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         2, 2));
        tbl.push_back(mk("sq2e",  1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         3, 2));
        tbl.push_back(mk("sq2f",  1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0002, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         2, 1));
        tbl.push_back(mk("sq2g",  1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1, 0));
        tbl.push_back(mk("sq2h",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        // squash with a request firing in the same cycle: that request is live
        tbl.push_back(mk("sqfa",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        tbl.push_back(mk("sqfb",  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1, 0));
        tbl.push_back(mk("sqfc",  1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0003, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         2, 1));
        tbl.push_back(mk("sqfd",  1'b0, 1'b0, 1'b0, 1'b1, 32'h0020_0113, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0020_0113, 1, 0));
        // squash coinciding with a response, one other in flight
        tbl.push_back(mk("sqra",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        tbl.push_back(mk("sqrb",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1, 0));
        tbl.push_back(mk("sqrc",  1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD0_0004, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         2, 0));
        tbl.push_back(mk("sqrd",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1, 1));
        tbl.push_back(mk("sqre",  1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0005, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1, 1));
        tbl.push_back(mk("sqrf",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        // squash with a full FIFO
        tbl.push_back(mk("sqxa",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        tbl.push_back(mk("sqxb",  1'b0, 1'b1, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3333_3333, 1, 0));
        tbl.push_back(mk("sqxc",  1'b0, 1'b0, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 1, 0));
        tbl.push_back(mk("sqxd",  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         0, 0));
        tbl.push_back(mk("sqxe",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Reset mid-stream with one in flight and one buffered, then resume.
        apply(mk("mrs0",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        apply(mk("mrs1",  1'b0, 1'b1, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_5555, 1, 0));
        apply(mk("mrs2",  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1, 0));
        apply(mk("mrs3",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        apply(mk("mrs4",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        apply(mk("mrs5",  1'b0, 1'b0, 1'b0, 1'b1, 32'h0030_0193, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0030_0193, 1, 0));
        apply(mk("mrs6",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));

        // Enqueue and dequeue in the same cycle keeps occupancy at one.
        apply(mk("edq0",  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));
        apply(mk("edq1",  1'b0, 1'b1, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b1, 1'b1, 1'b1, 32'h6666_6666, 1, 0));
        apply(mk("edq2",  1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 1'b1, 1'b1, 32'h6666_6666, 1, 0));
        apply(mk("edq3",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h7777_7777, 0, 0));
        apply(mk("edq4",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
